// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encoding and controller state for the calculator sequencer.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_AND = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  typedef enum logic [2:0] {
    ENTER_A, ENTER_B, EXEC, WAIT, RESULT, ERR
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_AND);
  endfunction

  // Operator keys A..D map onto ALU ops 0..3 in order.
  function automatic logic [1:0] key2op(input logic [3:0] k);
    logic [3:0] t;
    t = k - KEY_ADD;
    return t[1:0];
  endfunction

endpackage

// File: rtl/calc_dec_acc.sv
// Decimal entry step: sum = acc*10 + digit, flagging any result above 255.
module calc_dec_acc (
  input  logic [7:0] acc_i,
  input  logic [3:0] digit_i,
  output logic [7:0] sum_o,
  output logic       ovf_o
);

  logic [11:0] wide;

  assign wide  = ({4'd0, acc_i} * 12'd10) + {8'd0, digit_i};
  assign sum_o = wide[7:0];
  assign ovf_o = |wide[11:8];

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad-driven calculator sequencer: operand entry, ALU handshake with timeout, result/error display.
// Define CALC_SEQ_CHAIN_EN to let an operator key in RESULT chain on the previous result.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       alu_start,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_ovf,
  output logic [7:0] disp_value,
  output logic       disp_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]    op_q, op_d;
  logic          bdig_q, bdig_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       key_acc;
  logic [7:0] acc_in, dig_sum;
  logic       dig_ovf;

  // One accumulator serves both operands; the state picks which one is being typed.
  assign acc_in = (state_q == ENTER_B) ? b_q : a_q;

  calc_dec_acc u_acc (
    .acc_i   (acc_in),
    .digit_i (key_code),
    .sum_o   (dig_sum),
    .ovf_o   (dig_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      bdig_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      bdig_q  <= bdig_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    bdig_d    = bdig_q;
    cnt_d     = cnt_q;
    key_ready = (state_q != EXEC) && (state_q != WAIT);
    key_acc   = key_valid && key_ready;

    case (state_q)
      ENTER_A, ENTER_B: begin
        if (key_acc) begin
          if (is_digit(key_code)) begin
            if (dig_ovf) begin
              state_d = ERR;
            end else if (state_q == ENTER_A) begin
              a_d = dig_sum;
            end else begin
              b_d    = dig_sum;
              bdig_d = 1'b1;
            end
          end else if (is_op(key_code)) begin
            if (state_q == ENTER_A) begin
              op_d    = key2op(key_code);
              b_d     = '0;
              bdig_d  = 1'b0;
              state_d = ENTER_B;
            end else if (!bdig_q) begin
              op_d = key2op(key_code);
            end
          end else if (key_code == KEY_EQ && state_q == ENTER_B) begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (alu_done) begin
          if (alu_ovf) begin
            state_d = ERR;
          end else begin
            res_d   = alu_result;
            state_d = RESULT;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESULT: begin
        if (key_acc && is_digit(key_code)) begin
          a_d     = {4'd0, key_code};
          b_d     = '0;
          bdig_d  = 1'b0;
          state_d = ENTER_A;
        end
`ifdef CALC_SEQ_CHAIN_EN
        else if (key_acc && is_op(key_code)) begin
          a_d     = res_q;
          op_d    = key2op(key_code);
          b_d     = '0;
          bdig_d  = 1'b0;
          state_d = ENTER_B;
        end
`endif
      end
      default: ;
    endcase

    // Clear wins over everything else wherever a key is being accepted.
    if (key_acc && key_code == KEY_CLR) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      bdig_d  = 1'b0;
    end
  end

  assign alu_start = (state_q == EXEC);
  assign busy      = (state_q == EXEC) || (state_q == WAIT);
  assign disp_err  = (state_q == ERR);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;

  always_comb begin
    disp_value = '0;
    case (state_q)
      ENTER_A:            disp_value = a_q;
      ENTER_B:            disp_value = bdig_q ? b_q : a_q;
      EXEC, WAIT, RESULT: disp_value = res_q;
      default:            disp_value = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed table, corner sequences, random run vs a behavioural model.
module tb_calc_seq_ctrl;

  localparam int TO = 15;
  localparam int M_A = 0, M_B = 1, M_EX = 2, M_WT = 3, M_RS = 4, M_ER = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready, alu_start;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       alu_ovf;
  logic [7:0] disp_value;
  logic       disp_err, busy;

  calc_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .disp_value(disp_value), .disp_err(disp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode, m_a, m_b, m_op, m_res, m_bdig, m_wn;

  typedef struct {
    bit kv; int kc; bit done; bit ovf; int res;
    int e_disp; bit e_err; bit e_busy; bit e_rdy; bit e_start;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_bdig = 0; m_wn = 0;
  endtask

  // Calculator behaviour for one clock, in terms of what the user sees.
  task automatic model_step(input bit kv, input int kc, input bit done, input bit ovf, input int res);
    bit take;
    int v;
    take = kv && (m_mode != M_EX) && (m_mode != M_WT);
    if (take && kc == 15) begin
      m_mode = M_A; m_a = 0; m_b = 0; m_bdig = 0;
      return;
    end
    case (m_mode)
      M_A, M_B: if (take) begin
        if (kc < 10) begin
          v = ((m_mode == M_A) ? m_a : m_b) * 10 + kc;
          if (v > 255) m_mode = M_ER;
          else if (m_mode == M_A) m_a = v;
          else begin m_b = v; m_bdig = 1; end
        end else if (kc <= 13) begin
          if (m_mode == M_A) begin m_op = kc - 10; m_b = 0; m_bdig = 0; m_mode = M_B; end
          else if (m_bdig == 0) m_op = kc - 10;
        end else if (kc == 14 && m_mode == M_B) m_mode = M_EX;
      end
      M_EX: begin m_mode = M_WT; m_wn = 0; end
      M_WT: begin
        if (done) begin
          if (ovf) m_mode = M_ER;
          else begin m_res = res; m_mode = M_RS; end
        end else begin
          m_wn++;
          if (m_wn == TO) m_mode = M_ER;
        end
      end
      M_RS: if (take) begin
        if (kc < 10) begin m_a = kc; m_b = 0; m_bdig = 0; m_mode = M_A; end
`ifdef CALC_SEQ_CHAIN_EN
        else if (kc <= 13) begin m_a = m_res; m_op = kc - 10; m_b = 0; m_bdig = 0; m_mode = M_B; end
`endif
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    int ed;
    case (m_mode)
      M_A:     ed = m_a;
      M_B:     ed = m_bdig ? m_b : m_a;
      M_ER:    ed = 0;
      default: ed = m_res;
    endcase
    chk("disp_value", disp_value, ed);
    chk("disp_err", disp_err, m_mode == M_ER);
    chk("busy", busy, (m_mode == M_EX) || (m_mode == M_WT));
    chk("key_ready", key_ready, (m_mode != M_EX) && (m_mode != M_WT));
    chk("alu_start", alu_start, m_mode == M_EX);
    if (m_mode == M_EX || m_mode == M_WT) begin
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
    end
  endtask

  task automatic step(input bit kv, input int kc, input bit done, input bit ovf, input int res);
    key_valid  = kv;
    key_code   = kc[3:0];
    alu_done   = done;
    alu_ovf    = ovf;
    alu_result = res[7:0];
    model_step(kv, kc, done, ovf, res);
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic key(input int kc);
    step(1'b1, kc, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_valid = 1'b0; key_code = '0; alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
    model_reset();
    #1;
    compare_model();
    chk("rst_disp", disp_value, 0);
    chk("rst_ready", key_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, nw, lat, kc, full;
    bit kv, done, ovf;

    //             kv kc  dn ov res  disp err busy rdy start
    tbl[0]  = '{1, 1,  0, 0, 0,   1,   0, 0, 1, 0};
    tbl[1]  = '{1, 2,  0, 0, 0,   12,  0, 0, 1, 0};
    tbl[2]  = '{1, 10, 0, 0, 0,   12,  0, 0, 1, 0};
    tbl[3]  = '{1, 3,  0, 0, 0,   3,   0, 0, 1, 0};
    tbl[4]  = '{1, 14, 0, 0, 0,   0,   0, 1, 0, 1};
    tbl[5]  = '{0, 0,  0, 0, 0,   0,   0, 1, 0, 0};
    tbl[6]  = '{0, 0,  0, 0, 0,   0,   0, 1, 0, 0};
    tbl[7]  = '{0, 0,  1, 0, 15,  15,  0, 0, 1, 0};
    tbl[8]  = '{1, 2,  0, 0, 0,   2,   0, 0, 1, 0};
    tbl[9]  = '{1, 5,  0, 0, 0,   25,  0, 0, 1, 0};
    tbl[10] = '{1, 6,  0, 0, 0,   0,   1, 0, 1, 0};
    tbl[11] = '{1, 15, 0, 0, 0,   0,   0, 0, 1, 0};

    rst = 1'b0;
    key_valid = 1'b0; key_code = '0; alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
    #2;
    do_reset();

    starts = 0;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].done, tbl[i].ovf, tbl[i].res);
      if (alu_start) starts++;
      chk($sformatf("tbl%0d_disp", i), disp_value, tbl[i].e_disp);
      chk($sformatf("tbl%0d_err", i), disp_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ready", i), key_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_start", i), alu_start, tbl[i].e_start);
      if (i == 4) begin
        chk("tbl_alu_a", alu_a, 12);
        chk("tbl_alu_b", alu_b, 3);
        chk("tbl_alu_op", alu_op, 0);
      end
      if (i == 7) chk("tbl_start_pulses", starts, 1);
    end

    // Timeout with a digit held on the keypad throughout WAIT.
    key(5); key(11); key(7); key(14);
    nw = 0;
    for (int i = 0; i < 40 && !disp_err; i++) begin
      step(1'b1, 3, 1'b0, 1'b0, 0);
      if (busy) begin
        nw++;
        chk("wait_ready_low", key_ready, 0);
        chk("wait_a_held", alu_a, 5);
        chk("wait_b_held", alu_b, 7);
      end
    end
    chk("timeout_wait_cycles", nw, TO);
    chk("timeout_err", disp_err, 1);
    key(15);

    // Result 9, then operator / digit / equals.
    key(4); key(10); key(5); key(14);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 9);
    chk("res9_disp", disp_value, 9);
    key(12);
    chk("chain_c_disp", disp_value, 9);
    key(2);
    chk("chain_2_disp", disp_value, 2);
    key(14);
`ifdef CALC_SEQ_CHAIN_EN
    chk("chain_busy", busy, 1);
    chk("chain_alu_a", alu_a, 9);
    chk("chain_alu_b", alu_b, 2);
    chk("chain_alu_op", alu_op, 2);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 18);
`else
    chk("nochain_busy", busy, 0);
    chk("nochain_disp", disp_value, 2);
`endif
    key(15);

    // Reset in the middle of WAIT, followed by a late alu_done.
    key(1); key(10); key(1); key(14);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", key_ready, 1);
    chk("async_rst_disp", disp_value, 0);
    chk("async_rst_start", alu_start, 0);
    chk("async_rst_err", disp_err, 0);
    alu_done = 1'b1; alu_result = 8'd77; alu_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 0, 1'b1, 1'b0, 77);
    chk("late_done_disp", disp_value, 0);
    chk("late_done_busy", busy, 0);

    // Random keys and ALU latencies against the model.
    lat = 0;
    for (int n = 0; n < 1500; n++) begin
      kv = ($urandom_range(0, 3) != 0);
      kc = $urandom_range(0, 15);
      done = 1'b0; ovf = 1'b0; full = 0;
      if (m_mode == M_WT) begin
        if (lat == 0) begin
          done = 1'b1;
          case (m_op)
            0:       begin full = m_a + m_b; ovf = (full > 255); end
            1:       begin full = m_a - m_b; ovf = (m_a < m_b); end
            2:       begin full = m_a * m_b; ovf = (full > 255); end
            default: full = m_a & m_b;
          endcase
        end else lat--;
      end else begin
        done = ($urandom_range(0, 7) == 0);
        full = $urandom_range(0, 255);
      end
      step(kv, kc, done, ovf, full & 255);
      if (m_mode == M_EX) lat = $urandom_range(0, 17);
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
